mem_access_ctrl: RTL and testbench

Sequencer for the LC-3 memory datapath (MAR, MDR, synchronous RAM). It accepts one read or write request at a time from the main control unit and generates the MAR/MDR load, MDR-mux select and RAM write-enable strobes in the correct order. Bus-phase outputs tell the requester when to drive the address or the store data onto the shared Bus. A one-cycle ack closes each transaction.

---
 rtl/mem_access_if.sv | 26 ++
 rtl/mem_access_ctrl.sv | 112 +++++++++++
 tb/tb_mem_access_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Handshake and strobe bundle between the LC-3 control unit,
// the memory sequencer and the MAR/MDR/RAM datapath.
interface mem_access_if;
    logic req;
    logic rw;
    logic ack;
    logic busy;
    logic addr_phase;
    logic data_phase;
    logic ldMAR;
    logic ldMDR;
    logic memWE;
    logic selMDR;

    modport master (
        output req, rw,
        input  ack, busy, addr_phase, data_phase,
        input  ldMAR, ldMDR, memWE, selMDR
    );

    modport slave (
        input  req, rw,
        output ack, busy, addr_phase, data_phase,
        output ldMAR, ldMDR, memWE, selMDR
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 memory sequencer: orders MAR/MDR loads and RAM write strobes
// for one read or write at a time, closing each with a one-cycle ack.
module mem_access_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CW      = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  mac
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CAPT,
        WDATA,
        WRITE,
        DONE
    } state_t;

    localparam logic [CW-1:0] LOAD =
        CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          rw_q;
    logic          rw_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            rw_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rw_q  <= rw_n;
        end
    end

    // rw is captured only on acceptance; later changes are ignored
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rw_n    = rw_q;
        unique case (state)
            IDLE: begin
                if (mac.req) begin
                    rw_n    = mac.rw;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (rw_q) begin
                    state_n = WDATA;
                end else if (MEM_LAT == 0) begin
                    state_n = CAPT;
                end else begin
                    state_n = WAIT;
                    cnt_n   = LOAD;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = CAPT;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            CAPT:    state_n = DONE;
            WDATA:   state_n = WRITE;
            WRITE:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Moore outputs: reset forces IDLE, so all strobes drop at once
    always_comb begin
        mac.ack        = 1'b0;
        mac.addr_phase = 1'b0;
        mac.data_phase = 1'b0;
        mac.ldMAR      = 1'b0;
        mac.ldMDR      = 1'b0;
        mac.memWE      = 1'b0;
        mac.selMDR     = 1'b0;
        mac.busy       = (state != IDLE);
        unique case (state)
            IDLE: ;
            ADDR: begin
                mac.ldMAR      = 1'b1;
                mac.addr_phase = 1'b1;
            end
            WAIT: ;
            CAPT: begin
                mac.ldMDR  = 1'b1;
                mac.selMDR = 1'b1;
            end
            WDATA: begin
                mac.ldMDR      = 1'b1;
                mac.data_phase = 1'b1;
            end
            WRITE: mac.memWE = 1'b1;
            DONE:  mac.ack   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised and directed bench for mem_access_ctrl at MEM_LAT 0, 1, 3,
// with a small MAR/MDR/RAM datapath around the MEM_LAT=1 instance.
module tb_mem_access_ctrl;

    localparam logic [7:0] V_ADDR  = 8'b0110_1000;
    localparam logic [7:0] V_WAIT  = 8'b0100_0000;
    localparam logic [7:0] V_CAPT  = 8'b0100_0101;
    localparam logic [7:0] V_WDATA = 8'b0101_0100;
    localparam logic [7:0] V_WRITE = 8'b0100_0010;
    localparam logic [7:0] V_DONE  = 8'b1100_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        rw;
    logic [15:0] cur_addr;
    logic [15:0] cur_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_if if0 ();
    mem_access_if if1 ();
    mem_access_if if3 ();

    assign if0.req = req;
    assign if0.rw  = rw;
    assign if1.req = req;
    assign if1.rw  = rw;
    assign if3.req = req;
    assign if3.rw  = rw;

    mem_access_ctrl #(.MEM_LAT(0)) u_l0 (
        .clk(clk), .reset(rst_n), .mac(if0)
    );
    mem_access_ctrl #(.MEM_LAT(1)) u_l1 (
        .clk(clk), .reset(rst_n), .mac(if1)
    );
    mem_access_ctrl #(.MEM_LAT(3)) u_l3 (
        .clk(clk), .reset(rst_n), .mac(if3)
    );

    logic [7:0] ov [3];
    assign ov[0] = {if0.ack, if0.busy, if0.addr_phase, if0.data_phase,
                    if0.ldMAR, if0.ldMDR, if0.memWE, if0.selMDR};
    assign ov[1] = {if1.ack, if1.busy, if1.addr_phase, if1.data_phase,
                    if1.ldMAR, if1.ldMDR, if1.memWE, if1.selMDR};
    assign ov[2] = {if3.ack, if3.busy, if3.addr_phase, if3.data_phase,
                    if3.ldMAR, if3.ldMDR, if3.memWE, if3.selMDR};

    // datapath environment for the MEM_LAT=1 instance
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] q;
    logic [15:0] ram [16];
    logic [15:0] bus;
    int          fill = 0;

    assign bus = if1.addr_phase ? cur_addr : cur_data;

    always @(posedge clk) begin
        if (fill < 16) begin
            ram[fill[3:0]] <= 16'hA500 + 16'(fill);
            fill <= fill + 1;
        end else if (if1.memWE) begin
            ram[mar[3:0]] <= mdr;
        end
        if (if1.ldMAR) mar <= bus;
        if (if1.ldMDR) mdr <= if1.selMDR ? q : bus;
        q <= ram[mar[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    // expected strobes from cycles elapsed since acceptance
    function automatic logic [7:0] expv(input int lat, input bit act,
                                        input bit w, input int k);
        if (!act) return 8'h00;
        if (w) begin
            case (k)
                1:       return V_ADDR;
                2:       return V_WDATA;
                3:       return V_WRITE;
                default: return V_DONE;
            endcase
        end
        if (k == 1) return V_ADDR;
        if (k <= 1 + lat) return V_WAIT;
        if (k == 2 + lat) return V_CAPT;
        return V_DONE;
    endfunction

    bit act [3];
    bit mrw [3];
    int k   [3];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    act[i] = 1'b0;
                end else if (!act[i]) begin
                    if (req) begin
                        act[i] = 1'b1;
                        mrw[i] = rw;
                        k[i]   = 1;
                    end
                end else if (k[i] == (mrw[i] ? 4 : 3 + lat_of(i))) begin
                    act[i] = 1'b0;
                end else begin
                    k[i] = k[i] + 1;
                end
            end
        end
    end

    logic [15:0] mmem [16];
    logic [15:0] t_addr;
    logic [15:0] t_data;

    initial begin
        logic [7:0] e;
        for (int i = 0; i < 16; i++) mmem[i] = 16'hA500 + 16'(i);
        t_addr = '0;
        t_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = expv(lat_of(i), act[i], mrw[i], k[i]);
                chk($sformatf("vec_L%0d", lat_of(i)), 32'(ov[i]), 32'(e));
            end
            e = expv(1, act[1], mrw[1], k[1]);
            if (e == V_ADDR)  t_addr = cur_addr;
            if (e == V_WDATA) t_data = cur_data;
            if (e == V_WRITE) mmem[t_addr[3:0]] = t_data;
            if (e == V_DONE && !mrw[1])
                chk("rdata", 32'(mdr), 32'(mmem[t_addr[3:0]]));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((if0.busy || if1.busy || if3.busy) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_bound", 32'(n < 60), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic txn(input logic w, input bit hold, input bit glitch,
                       input logic [15:0] a, input logic [15:0] d,
                       output int a0, output int a1, output int a3,
                       output int selm, output int wes,
                       output int waits, output int acks);
        int c = 0;
        cur_addr = a;
        cur_data = d;
        req = 1'b1;
        rw  = w;
        a0 = -1; a1 = -1; a3 = -1;
        selm = 0; wes = 0; waits = 0; acks = 0;
        while ((a0 < 0 || a1 < 0 || a3 < 0) && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (glitch) rw = (c <= 3);
            if (!hold) req = 1'b0;
            if (if0.ack && a0 < 0) a0 = c;
            if (if1.ack && a1 < 0) a1 = c;
            if (if3.ack && a3 < 0) a3 = c;
            if (if1.ack) acks++;
            if (if1.selMDR) selm |= (1 << c);
            if (if1.memWE || if1.data_phase) wes++;
            if (ov[2] == V_WAIT) waits++;
            if (if1.ack && hold) req = 1'b0;
        end
        chk("txn_bound", 32'(c < 40), 32'd1);
        req = 1'b0;
        rw  = 1'b0;
        wait_idle();
    endtask

    initial begin
        int a0, a1, a3, selm, wes, waits, acks;
        int c1, c2, n;
        logic [15:0] old;

        req = 1'b0;
        rw = 1'b0;
        cur_addr = 16'h3000;
        cur_data = 16'h0000;
        rst_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_L0", 32'(ov[0]), 32'd0);
        chk("rst_L1", 32'(ov[1]), 32'd0);
        chk("rst_L3", 32'(ov[2]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write then read back
        txn(1'b1, 1'b1, 1'b0, 16'h3000, 16'h1234,
            a0, a1, a3, selm, wes, waits, acks);
        chk("wr_ack_L1", 32'(a1), 32'd4);
        chk("wr_ack_L0", 32'(a0), 32'd4);
        chk("wr_ack_L3", 32'(a3), 32'd4);
        chk("wr_ram", 32'(ram[0]), 32'h1234);
        txn(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000,
            a0, a1, a3, selm, wes, waits, acks);
        chk("rd_ack_L1", 32'(a1), 32'd4);
        chk("rd_mdr", 32'(mdr), 32'h1234);
        chk("rd_sel", 32'(selm), 32'(1 << 3));

        // latency sweep with a one-cycle req pulse
        txn(1'b0, 1'b0, 1'b0, 16'h3002, 16'h0000,
            a0, a1, a3, selm, wes, waits, acks);
        chk("lat_L0", 32'(a0), 32'd3);
        chk("lat_L1", 32'(a1), 32'd4);
        chk("lat_L3", 32'(a3), 32'd6);
        chk("wait_L3", 32'(waits), 32'd3);
        chk("pulse_acks", 32'(acks), 32'd1);
        chk("pulse_mdr", 32'(mdr), 32'(mmem[2]));

        // rw forced high after a read is accepted
        txn(1'b0, 1'b1, 1'b1, 16'h3000, 16'hFFFF,
            a0, a1, a3, selm, wes, waits, acks);
        chk("glitch_we", 32'(wes), 32'd0);
        chk("glitch_ack", 32'(a1), 32'd4);
        chk("glitch_mdr", 32'(mdr), 32'h1234);

        // back-to-back reads with req held
        cur_addr = 16'h3000;
        req = 1'b1;
        rw = 1'b0;
        c1 = -1; c2 = -1; n = 0;
        while (c2 < 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (if1.ack) begin
                if (c1 < 0) begin
                    c1 = n;
                    chk("b2b_mdr0", 32'(mdr), 32'(mmem[0]));
                    cur_addr = 16'h3001;
                end else begin
                    c2 = n;
                    chk("b2b_mdr1", 32'(mdr), 32'(mmem[1]));
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        chk("b2b_first", 32'(c1), 32'd4);
        chk("b2b_gap", 32'(c2 - c1), 32'd5);
        wait_idle();

        // asynchronous reset in the middle of a write
        old = ram[5];
        cur_addr = 16'h3005;
        cur_data = 16'hBEEF;
        req = 1'b1;
        rw = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("pre_wdata", 32'(ov[1]), 32'(V_WDATA));
        #2 rst_n = 1'b0;
        #1;
        chk("async_L1", 32'(ov[1]), 32'd0);
        chk("async_L3", 32'(ov[2]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("ram_kept", 32'(ram[5]), 32'(old));
        @(posedge clk); #1;
        txn(1'b0, 1'b1, 1'b0, 16'h3005, 16'h0000,
            a0, a1, a3, selm, wes, waits, acks);
        chk("post_rst_ack", 32'(a1), 32'd4);
        chk("post_rst_mdr", 32'(mdr), 32'(old));

        // random traffic, with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 149) != 0);
            req = ($urandom_range(0, 2) != 0);
            rw = 1'($urandom_range(0, 1));
            cur_addr = 16'h3000 + 16'($urandom_range(0, 15));
            cur_data = 16'($urandom);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
